// File: rtl/uart_pkg.sv
// Shared UART constants and the command-assembler state encoding.
package uart_pkg;

  localparam logic [11:0] BAUD        = 12'hA2C;
  localparam logic [11:0] HBAUD       = 12'h516;
  localparam int          CMD_TIMEOUT = 78120;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_t;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Byte-in / command-out signal bundle of the UART command assembler.
interface uart_cmd_assembler_if;

  // Both sides use level-ready / pulse-clear handshakes:
  // - rx_rdy stays high until the assembler pulses clr_rx_rdy in the same
  //   cycle it consumes rx_data.
  // - cmd_rdy stays high until the consumer pulses clr_cmd_rdy.
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        overrun;
  logic        to_err;
  logic        clr_err;

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy, clr_err,
    output clr_rx_rdy, cmd, cmd_rdy, overrun, to_err
  );

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy, clr_err,
    input  clr_rx_rdy, cmd, cmd_rdy, overrun, to_err
  );

endinterface

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout down-counter: load to TIMEOUT-1, count down while enabled,
// saturate at zero.
module uart_timeout_cnt #(
  parameter int TIMEOUT = 78120,
  parameter int TO_W    = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [TO_W-1:0] LOAD_VAL = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs two UART bytes (high first) into a 16-bit command, with an
// inter-byte timeout and sticky overrun / timeout error flags.
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int TIMEOUT = CMD_TIMEOUT,
  parameter int TO_W    = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_cmd_assembler_if.slave   bus,
  output asm_state_t            dbg_state
);

  asm_state_t  state_q, state_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        overrun_q, overrun_d;
  logic        to_err_q, to_err_d;
  logic        cnt_load, cnt_en, cnt_zero;
  logic        complete, expire;

  uart_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .en    (cnt_en),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    hi_byte_d = hi_byte_q;
    cmd_d     = cmd_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    complete  = 1'b0;
    expire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_rdy) begin
          hi_byte_d = bus.rx_data;
          cnt_load  = 1'b1;
          state_d   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // An arriving low byte takes priority over a simultaneous expiry.
        if (bus.rx_rdy) begin
          cmd_d    = {hi_byte_q, bus.rx_data};
          complete = 1'b1;
          state_d  = IDLE;
        end else if (cnt_zero) begin
          expire    = 1'b1;
          hi_byte_d = 8'h00;
          state_d   = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_rdy_d = complete | (cmd_rdy_q & ~bus.clr_cmd_rdy);
    overrun_d = (complete & cmd_rdy_q & ~bus.clr_cmd_rdy) | (overrun_q & ~bus.clr_err);
    to_err_d  = expire | (to_err_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_byte_q <= 8'h00;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_byte_q <= hi_byte_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      overrun_q <= overrun_d;
      to_err_q  <= to_err_d;
    end
  end

  // Every waiting byte is consumed in either state, so the clear is just the
  // ready flag gated by reset.
  assign bus.clr_rx_rdy = rst_n & bus.rx_rdy;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.overrun    = overrun_q;
  assign bus.to_err     = to_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler with a short timeout.
module tb_uart_cmd_assembler;
  import uart_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;

  logic       clk;
  logic       rst_n;
  asm_state_t dbg_state;
  int         n_tests;
  int         n_fail;

  uart_cmd_assembler_if bus ();

  uart_cmd_assembler #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver and check tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    @(negedge clk);
    chk("clr_rx_rdy_pulse", 16'(bus.clr_rx_rdy), 16'd1);
    tick();
    bus.rx_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("clr_rx_rdy_quiet", 16'(bus.clr_rx_rdy), 16'd0);
      tick();
    end
  endtask

  task automatic pulse_clears(input logic c_cmd, input logic c_err);
    bus.clr_cmd_rdy = c_cmd;
    bus.clr_err     = c_err;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    bus.clr_err     = 1'b0;
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rx_rdy      = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.clr_err     = 1'b0;

    // Reset values, with rx_rdy held high to check the clear is gated off
    @(negedge clk);
    chk("rst_clr_rx_rdy", 16'(bus.clr_rx_rdy), 16'd0);
    chk("rst_cmd", bus.cmd, 16'h0000);
    chk("rst_cmd_rdy", 16'(bus.cmd_rdy), 16'd0);
    chk("rst_overrun", 16'(bus.overrun), 16'd0);
    chk("rst_to_err", 16'(bus.to_err), 16'd0);
    chk("rst_state", 16'(dbg_state), 16'(IDLE));
    bus.rx_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: basic command, bytes 5 cycles apart
    send_byte(8'hA5);
    idle(4);
    chk("t1_cmd_rdy_before", 16'(bus.cmd_rdy), 16'd0);
    send_byte(8'h3C);
    @(negedge clk);
    chk("t1_cmd", bus.cmd, 16'hA53C);
    chk("t1_cmd_rdy", 16'(bus.cmd_rdy), 16'd1);
    chk("t1_overrun", 16'(bus.overrun), 16'd0);
    chk("t1_to_err", 16'(bus.to_err), 16'd0);
    tick();
    pulse_clears(1'b1, 1'b0);
    @(negedge clk);
    chk("t1_cmd_rdy_clr", 16'(bus.cmd_rdy), 16'd0);
    chk("t1_cmd_hold", bus.cmd, 16'hA53C);
    tick();

    // 2: stranded high byte times out exactly TIMEOUT cycles after capture
    send_byte(8'h12);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      chk("t2_to_err_early", 16'(bus.to_err), 16'd0);
      chk("t2_state_wait", 16'(dbg_state), 16'(WAIT_LO));
      tick();
    end
    @(negedge clk);
    chk("t2_to_err_set", 16'(bus.to_err), 16'd1);
    chk("t2_state_idle", 16'(dbg_state), 16'(IDLE));
    tick();
    idle(3);
    send_byte(8'h34);
    send_byte(8'h56);
    @(negedge clk);
    chk("t2_cmd", bus.cmd, 16'h3456);
    chk("t2_cmd_rdy", 16'(bus.cmd_rdy), 16'd1);
    chk("t2_to_err_sticky", 16'(bus.to_err), 16'd1);
    tick();
    pulse_clears(1'b1, 1'b1);
    @(negedge clk);
    chk("t2_to_err_clr", 16'(bus.to_err), 16'd0);
    chk("t2_cmd_rdy_clr", 16'(bus.cmd_rdy), 16'd0);
    tick();

    // 3: low byte at exactly c+TIMEOUT is accepted
    send_byte(8'h77);
    for (int k = 1; k < TIMEOUT; k++) begin
      @(negedge clk);
      chk("t3_state_wait", 16'(dbg_state), 16'(WAIT_LO));
      tick();
    end
    send_byte(8'h88);
    @(negedge clk);
    chk("t3_cmd", bus.cmd, 16'h7788);
    chk("t3_cmd_rdy", 16'(bus.cmd_rdy), 16'd1);
    chk("t3_to_err", 16'(bus.to_err), 16'd0);
    chk("t3_state_idle", 16'(dbg_state), 16'(IDLE));
    tick();
    pulse_clears(1'b1, 1'b0);

    // 4: two commands without acknowledge -> overrun
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    chk("t4_cmd_first", bus.cmd, 16'h0102);
    chk("t4_overrun_first", 16'(bus.overrun), 16'd0);
    tick();
    send_byte(8'h03);
    send_byte(8'h04);
    @(negedge clk);
    chk("t4_overrun", 16'(bus.overrun), 16'd1);
    chk("t4_cmd", bus.cmd, 16'h0304);
    chk("t4_cmd_rdy", 16'(bus.cmd_rdy), 16'd1);
    tick();
    pulse_clears(1'b0, 1'b1);
    @(negedge clk);
    chk("t4_overrun_clr", 16'(bus.overrun), 16'd0);
    chk("t4_cmd_rdy_kept", 16'(bus.cmd_rdy), 16'd1);
    tick();

    // 5: acknowledge in the completion cycle -> cmd_rdy stays, no overrun
    send_byte(8'h05);
    bus.clr_cmd_rdy = 1'b1;
    send_byte(8'h06);
    bus.clr_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("t5_cmd_rdy", 16'(bus.cmd_rdy), 16'd1);
    chk("t5_overrun", 16'(bus.overrun), 16'd0);
    chk("t5_cmd", bus.cmd, 16'h0506);
    tick();

    // 5b: overrun set and clr_err together -> set wins
    send_byte(8'h07);
    bus.clr_err = 1'b1;
    send_byte(8'h08);
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("t5b_overrun_wins", 16'(bus.overrun), 16'd1);
    chk("t5b_cmd", bus.cmd, 16'h0708);
    tick();
    pulse_clears(1'b1, 1'b1);
    @(negedge clk);
    chk("t5b_overrun_clr", 16'(bus.overrun), 16'd0);
    chk("t5b_cmd_rdy_clr", 16'(bus.cmd_rdy), 16'd0);
    chk("t5b_cmd_hold", bus.cmd, 16'h0708);
    tick();

    // 6: asynchronous reset while holding a high byte
    send_byte(8'hEE);
    @(negedge clk);
    chk("t6_state_wait", 16'(dbg_state), 16'(WAIT_LO));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 16'(dbg_state), 16'(IDLE));
    chk("t6_rst_cmd", bus.cmd, 16'h0000);
    chk("t6_rst_cmd_rdy", 16'(bus.cmd_rdy), 16'd0);
    chk("t6_rst_overrun", 16'(bus.overrun), 16'd0);
    chk("t6_rst_to_err", 16'(bus.to_err), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    chk("t6_cmd", bus.cmd, 16'h1122);
    chk("t6_cmd_rdy", 16'(bus.cmd_rdy), 16'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
